// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter: sole owner of the regfile write port.
// Optional buffered-result forwarding is enabled by defining MDWB_FWD_EN.
module regfile_write_arbiter #(
  parameter int          PEND_DEPTH = 2,
  parameter logic [31:0] EXC_MUL    = 32'd4,
  parameter logic [31:0] EXC_DIV    = 32'd5
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        wb_we,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_data,
  input  logic        md_start,
  input  logic        md_is_div,
  input  logic [4:0]  md_rd,
  input  logic        md_RDY,
  input  logic [31:0] md_result,
  input  logic        md_exception,
  input  logic [4:0]  q_rs,
  input  logic [4:0]  q_rt,
  output logic        ctrl_writeEnable,
  output logic [4:0]  ctrl_writeReg,
  output logic [31:0] data_writeReg,
  output logic        wb_stall,
  output logic        md_busy,
  output logic        hazard,
  output logic        fwd_valid,
  output logic [31:0] fwd_data
);

  localparam int CW = $clog2(PEND_DEPTH + 1);

  logic [4:0]    b_rd   [PEND_DEPTH];
  logic [31:0]   b_data [PEND_DEPTH];
  logic [CW-1:0] count;
  logic          inflight;
  logic          if_div;
  logic [4:0]    if_rd;

  logic          full;
  logic          busy_raw;
  logic          win;
  logic [4:0]    win_rd;
  logic [31:0]   win_data;
  logic          pop;
  logic          push;
  logic          direct;
  int            push_idx;
  logic [4:0]    e_rd;
  logic [31:0]   e_data;
  logic          hit_rs;
  logic          hit_rt;
  logic          hz_if;
`ifdef MDWB_FWD_EN
  logic [31:0]   rs_d;
  logic [31:0]   rt_d;
`endif

  always_comb begin
    full     = count == CW'(PEND_DEPTH);
    busy_raw = inflight | full;
    e_rd     = md_exception ? 5'd30 : if_rd;
    e_data   = md_exception ? (if_div ? EXC_DIV : EXC_MUL) : md_result;
    win      = 1'b0;
    win_rd   = '0;
    win_data = '0;
    pop      = 1'b0;
    push     = 1'b0;
    direct   = 1'b0;
    if (full) begin
      win      = 1'b1;
      win_rd   = b_rd[0];
      win_data = b_data[0];
      pop      = 1'b1;
      push     = md_RDY;
    end else if (wb_we) begin
      win      = 1'b1;
      win_rd   = wb_rd;
      win_data = wb_data;
      push     = md_RDY;
    end else if (count != '0) begin
      win      = 1'b1;
      win_rd   = b_rd[0];
      win_data = b_data[0];
      pop      = 1'b1;
      push     = md_RDY;
    end else if (md_RDY) begin
      win      = 1'b1;
      win_rd   = e_rd;
      win_data = e_data;
      direct   = 1'b1;
    end
    push_idx         = int'(count) - int'(pop);
    ctrl_writeEnable = win & (win_rd != 5'd0) & ~reset;
    ctrl_writeReg    = ctrl_writeEnable ? win_rd : 5'd0;
    data_writeReg    = ctrl_writeEnable ? win_data : 32'd0;
    wb_stall         = full & wb_we & ~reset;
    md_busy          = busy_raw & ~reset;
  end

  // The head being written this cycle no longer counts as pending.
  always_comb begin
    hit_rs = 1'b0;
    hit_rt = 1'b0;
`ifdef MDWB_FWD_EN
    rs_d   = '0;
    rt_d   = '0;
`endif
    for (int i = 0; i < PEND_DEPTH; i++) begin
      if (i < int'(count) && !(pop && i == 0)) begin
        if (q_rs != 5'd0 && q_rs == b_rd[i]) begin
          hit_rs = 1'b1;
`ifdef MDWB_FWD_EN
          rs_d   = b_data[i];
`endif
        end
        if (q_rt != 5'd0 && q_rt == b_rd[i]) begin
          hit_rt = 1'b1;
`ifdef MDWB_FWD_EN
          rt_d   = b_data[i];
`endif
        end
      end
    end
    hz_if = inflight & ~direct &
            ((q_rs != 5'd0 && q_rs == if_rd) ||
             (q_rt != 5'd0 && q_rt == if_rd));
`ifdef MDWB_FWD_EN
    if (hit_rs) begin
      fwd_valid = ~reset;
      fwd_data  = reset ? 32'd0 : rs_d;
      hazard    = ~reset & (hz_if | (hit_rt & (q_rt != q_rs)));
    end else if (hit_rt) begin
      fwd_valid = ~reset;
      fwd_data  = reset ? 32'd0 : rt_d;
      hazard    = ~reset & hz_if;
    end else begin
      fwd_valid = 1'b0;
      fwd_data  = 32'd0;
      hazard    = ~reset & hz_if;
    end
`else
    fwd_valid = 1'b0;
    fwd_data  = 32'd0;
    hazard    = ~reset & (hz_if | hit_rs | hit_rt);
`endif
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      count    <= '0;
      inflight <= 1'b0;
      if_rd    <= '0;
      if_div   <= 1'b0;
    end else begin
      count <= count + CW'(push) - CW'(pop);
      if (md_start && !busy_raw) begin
        inflight <= 1'b1;
        if_rd    <= md_rd;
        if_div   <= md_is_div;
      end else if (md_RDY) begin
        inflight <= 1'b0;
      end
    end
  end

  // Shift-register FIFO: slot 0 is always the oldest entry.
  always_ff @(posedge clock) begin
    for (int i = 0; i < PEND_DEPTH; i++) begin
      if (pop && i < PEND_DEPTH - 1) begin
        b_rd[i]   <= b_rd[i+1];
        b_data[i] <= b_data[i+1];
      end
      if (push && i == push_idx) begin
        b_rd[i]   <= e_rd;
        b_data[i] <= e_data;
      end
    end
  end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb_regfile_write_arbiter: directed scenarios plus random traffic
// checked against a queue-based reference model.
module tb_regfile_write_arbiter;

  localparam int D = 3;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        wb_we = 1'b0;
  logic [4:0]  wb_rd = '0;
  logic [31:0] wb_data = '0;
  logic        md_start = 1'b0;
  logic        md_is_div = 1'b0;
  logic [4:0]  md_rd = '0;
  logic        md_RDY = 1'b0;
  logic [31:0] md_result = '0;
  logic        md_exception = 1'b0;
  logic [4:0]  q_rs = '0;
  logic [4:0]  q_rt = '0;
  logic        ctrl_writeEnable;
  logic [4:0]  ctrl_writeReg;
  logic [31:0] data_writeReg;
  logic        wb_stall;
  logic        md_busy;
  logic        hazard;
  logic        fwd_valid;
  logic [31:0] fwd_data;

  always #5 clock = ~clock;

  regfile_write_arbiter #(.PEND_DEPTH(D)) dut (
    .clock(clock), .reset(reset),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
    .md_start(md_start), .md_is_div(md_is_div), .md_rd(md_rd),
    .md_RDY(md_RDY), .md_result(md_result),
    .md_exception(md_exception),
    .q_rs(q_rs), .q_rt(q_rt),
    .ctrl_writeEnable(ctrl_writeEnable),
    .ctrl_writeReg(ctrl_writeReg),
    .data_writeReg(data_writeReg),
    .wb_stall(wb_stall), .md_busy(md_busy), .hazard(hazard),
    .fwd_valid(fwd_valid), .fwd_data(fwd_data)
  );

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] d;
  } ent_t;

  ent_t       mq[$];
  bit         m_if = 0;
  logic [4:0] m_rd = '0;
  bit         m_div = 0;
  bit         exp_stall = 0;
  int         total = 0;
  int         bad = 0;
  int         cyc_n = 0;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s cyc=%0d observed=%h expected=%h",
             tag, cyc_n, obs, exp);
    end
  endtask

  task automatic idle();
    wb_we = 0; wb_rd = 0; wb_data = 0;
    md_start = 0; md_is_div = 0;
    md_RDY = 0; md_result = 0; md_exception = 0;
    q_rs = 0; q_rt = 0;
  endtask

  // One clock: predict outputs, compare, advance the model at the edge.
  task automatic tick();
    ent_t e, w;
    ent_t pend[$];
    bit win, pop, push, direct, busy, hz_if, rs_b, rt_b, fv, hz;
    logic [31:0] fd;
    int rsi, rti;
    e.rd = md_exception ? 5'd30 : m_rd;
    e.d  = md_exception ? (m_div ? 32'd5 : 32'd4) : md_result;
    w.rd = 0; w.d = 0;
    win = 0; pop = 0; push = 0; direct = 0;
    busy = m_if || mq.size() == D;
    if (mq.size() == D) begin
      win = 1; w = mq[0]; pop = 1; push = md_RDY;
    end else if (wb_we) begin
      win = 1; w.rd = wb_rd; w.d = wb_data; push = md_RDY;
    end else if (mq.size() > 0) begin
      win = 1; w = mq[0]; pop = 1; push = md_RDY;
    end else if (md_RDY) begin
      win = 1; w = e; direct = 1;
    end
    pend = mq;
    if (pop) void'(pend.pop_front());
    rsi = -1; rti = -1;
    foreach (pend[i]) begin
      if (q_rs != 0 && pend[i].rd == q_rs) rsi = i;
      if (q_rt != 0 && pend[i].rd == q_rt) rti = i;
    end
    rs_b  = rsi >= 0;
    rt_b  = rti >= 0;
    hz_if = m_if && !direct &&
            ((q_rs != 0 && q_rs == m_rd) || (q_rt != 0 && q_rt == m_rd));
`ifdef MDWB_FWD_EN
    if (rs_b) begin
      fv = 1; fd = pend[rsi].d; hz = hz_if || (rt_b && q_rt != q_rs);
    end else if (rt_b) begin
      fv = 1; fd = pend[rti].d; hz = hz_if;
    end else begin
      fv = 0; fd = 0; hz = hz_if;
    end
`else
    fv = 0; fd = 0; hz = hz_if || rs_b || rt_b;
`endif
    if (reset) begin
      win = 0; fv = 0; fd = 0; hz = 0;
    end
    exp_stall = !reset && mq.size() == D && wb_we;
    #1;
    chk("we", ctrl_writeEnable, win && w.rd != 0);
    chk("reg", ctrl_writeReg, (win && w.rd != 0) ? w.rd : 5'd0);
    chk("data", data_writeReg, (win && w.rd != 0) ? w.d : 32'd0);
    chk("stall", wb_stall, exp_stall);
    chk("busy", md_busy, busy && !reset);
    chk("hazard", hazard, hz);
    chk("fwd_valid", fwd_valid, fv);
    chk("fwd_data", fwd_data, fd);
    @(posedge clock);
    if (reset) begin
      mq.delete();
      m_if = 0;
    end else begin
      if (pop) void'(mq.pop_front());
      if (push) mq.push_back(e);
      if (md_start && !busy) begin
        m_if = 1; m_rd = md_rd; m_div = md_is_div;
      end else if (md_RDY) begin
        m_if = 0;
      end
    end
    @(negedge clock);
    cyc_n++;
  endtask

  initial begin
    int lat;
    idle();
    @(negedge clock);
    reset = 1;
    tick();
    tick();
    reset = 0;
    #1;
    chk("rst_we", ctrl_writeEnable, 1'b0);
    chk("rst_busy", md_busy, 1'b0);

    // 1: direct write of an unopposed result
    md_start = 1; md_rd = 5;
    tick();
    md_start = 0; md_RDY = 1; md_result = 32'h2A;
    #1;
    chk("t1_we", ctrl_writeEnable, 1'b1);
    chk("t1_reg", ctrl_writeReg, 5'd5);
    chk("t1_data", data_writeReg, 32'h2A);
    tick();
    idle();
    #1;
    chk("t1_busy", md_busy, 1'b0);
    tick();

    // 2: result loses to writeback and is buffered
    md_start = 1; md_rd = 7;
    tick();
    md_start = 0; md_RDY = 1; md_result = 32'h11;
    wb_we = 1; wb_rd = 3; wb_data = 32'h99; q_rs = 7;
    #1;
    chk("t2_reg_wb", ctrl_writeReg, 5'd3);
    chk("t2_hz_pend", hazard, 1'b1);
    tick();
    idle();
    q_rs = 7;
    #1;
    chk("t2_reg_md", ctrl_writeReg, 5'd7);
    chk("t2_data_md", data_writeReg, 32'h11);
    chk("t2_hz_clr", hazard, 1'b0);
    tick();
    idle();

    // 3: fill the buffer behind continuous writeback
    for (int k = 0; k < D; k++) begin
      md_start = 1; md_rd = 5'(20 + k); md_RDY = 0;
      wb_we = 1; wb_rd = 5'(k + 1); wb_data = k;
      tick();
      md_start = 0; md_RDY = 1; md_result = 32'hA0 + k;
      tick();
      md_RDY = 0;
    end
    wb_we = 1; wb_rd = 4; wb_data = 32'h44;
    #1;
    chk("t3_busy", md_busy, 1'b1);
    chk("t3_stall", wb_stall, 1'b1);
    chk("t3_head", ctrl_writeReg, 5'd20);
    tick();
    #1;
    chk("t3_unstall", wb_stall, 1'b0);
    chk("t3_wb_reg", ctrl_writeReg, 5'd4);
    tick();
    idle();
    tick();
    tick();

    // 4: exception writes to r30
    md_start = 1; md_rd = 8; md_is_div = 1;
    tick();
    idle();
    md_RDY = 1; md_exception = 1; md_result = 32'h1234;
    #1;
    chk("t4_div_reg", ctrl_writeReg, 5'd30);
    chk("t4_div_data", data_writeReg, 32'd5);
    tick();
    idle();
    md_start = 1; md_rd = 8; md_is_div = 0;
    tick();
    idle();
    md_RDY = 1; md_exception = 1;
    #1;
    chk("t4_mul_data", data_writeReg, 32'd4);
    tick();
    idle();

    // 6: buffered entry seen by decode
    md_start = 1; md_rd = 9;
    tick();
    md_start = 0; md_RDY = 1; md_result = 32'hBEEF;
    wb_we = 1; wb_rd = 1; wb_data = 1;
    tick();
    md_RDY = 0; q_rt = 9;
    #1;
`ifdef MDWB_FWD_EN
    chk("t6_fv", fwd_valid, 1'b1);
    chk("t6_fd", fwd_data, 32'hBEEF);
    chk("t6_hz", hazard, 1'b0);
`else
    chk("t6_fv", fwd_valid, 1'b0);
    chk("t6_hz", hazard, 1'b1);
`endif
    tick();
    idle();
    tick();

    // 5: reset with two buffered entries and one in flight
    for (int k = 0; k < 2; k++) begin
      md_start = 1; md_rd = 5'(12 + k);
      wb_we = 1; wb_rd = 2; wb_data = 2;
      tick();
      md_start = 0; md_RDY = 1; md_result = 32'hC0 + k;
      tick();
      md_RDY = 0;
    end
    md_start = 1; md_rd = 14;
    tick();
    idle();
    reset = 1;
    tick();
    reset = 0;
    q_rs = 12; q_rt = 14;
    #1;
    chk("t5_we", ctrl_writeEnable, 1'b0);
    chk("t5_busy", md_busy, 1'b0);
    chk("t5_hz", hazard, 1'b0);
    chk("t5_stall", wb_stall, 1'b0);
    for (int k = 0; k < 3; k++) tick();

    // random traffic
    lat = 0;
    for (int n = 0; n < 600; n++) begin
      reset = ($urandom_range(0, 79) == 0);
      if (!exp_stall) begin
        wb_we   = $urandom_range(0, 1);
        wb_rd   = 5'($urandom_range(0, 31));
        wb_data = $urandom;
      end
      md_start = 0; md_RDY = 0; md_exception = 0;
      if (m_if) begin
        md_rd = m_rd;
        if (lat == 0) begin
          md_RDY = 1;
          md_result = $urandom;
          md_exception = ($urandom_range(0, 7) == 0);
        end else begin
          lat--;
        end
      end else if (mq.size() < D && $urandom_range(0, 1) == 1) begin
        md_start  = 1;
        md_rd     = 5'($urandom_range(0, 15));
        md_is_div = $urandom_range(0, 1);
        lat       = $urandom_range(0, 3);
      end
      q_rs = 5'($urandom_range(0, 15));
      q_rt = 5'($urandom_range(0, 31));
      tick();
    end
    reset = 0;
    idle();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
